// File: rtl/otter_mem_arbiter_if.sv
// rtl/otter_mem_arbiter_if.sv - requester and memory-port bundle for the OTTER memory arbiter
interface otter_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              IF_REQ;
    logic [ADDR_W-1:0] IF_ADDR;
    logic              IF_GNT;
    logic              IF_VALID;
    logic [DATA_W-1:0] IF_RDATA;

    logic              D_REQ;
    logic              D_WE;
    logic [ADDR_W-1:0] D_ADDR;
    logic [DATA_W-1:0] D_WDATA;
    logic [1:0]        D_SIZE;
    logic              D_SIGN;
    logic              D_GNT;
    logic              D_VALID;
    logic [DATA_W-1:0] D_RDATA;

    logic              MEM_EN;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic [1:0]        MEM_SIZE;
    logic              MEM_SIGN;
    logic [DATA_W-1:0] MEM_RDATA;

    logic              STALL;

    modport slave (
        input  IF_REQ, IF_ADDR,
        input  D_REQ, D_WE, D_ADDR, D_WDATA, D_SIZE, D_SIGN,
        input  MEM_RDATA,
        output IF_GNT, IF_VALID, IF_RDATA,
        output D_GNT, D_VALID, D_RDATA,
        output MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_SIZE, MEM_SIGN,
        output STALL
    );

    modport master (
        output IF_REQ, IF_ADDR,
        output D_REQ, D_WE, D_ADDR, D_WDATA, D_SIZE, D_SIGN,
        output MEM_RDATA,
        input  IF_GNT, IF_VALID, IF_RDATA,
        input  D_GNT, D_VALID, D_RDATA,
        input  MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_SIZE, MEM_SIGN,
        input  STALL
    );
endinterface

// File: rtl/otter_mem_arbiter.sv
// rtl/otter_mem_arbiter.sv - fetch/data arbiter for one fixed-latency memory port
module otter_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LAT        = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic          CLK,
    input  logic          RST,
    otter_mem_arbiter_if.slave bus
);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic [3:0]        starve_cnt;
    logic              if_gnt;
    logic              d_gnt;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_size;
    logic              mem_sign;

    // One tag per in-flight access; stage LAT-1 lines up with MEM_RDATA.
    logic [LAT-1:0]    tag_v;
    logic [LAT-1:0]    tag_d;
    logic [LAT-1:0]    tag_w;

    logic              if_valid;
    logic              d_valid;
    logic              d_is_write;

    always_comb begin
        if_gnt    = bus.IF_REQ & (~bus.D_REQ | (starve_cnt == SMAX));
        d_gnt     = bus.D_REQ & ~if_gnt;
        mem_en    = if_gnt | d_gnt;
        mem_addr  = '0;
        mem_size  = 2'b00;
        mem_sign  = 1'b0;
        if (if_gnt) begin
            mem_addr = bus.IF_ADDR;
            mem_size = 2'b10;
        end else if (d_gnt) begin
            mem_addr = bus.D_ADDR;
            mem_size = bus.D_SIZE;
            mem_sign = bus.D_SIGN;
        end
        mem_wdata = mem_en ? bus.D_WDATA : '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            starve_cnt <= 4'd0;
        end else if (if_gnt || !bus.IF_REQ) begin
            starve_cnt <= 4'd0;
        end else if (d_gnt && (starve_cnt != SMAX)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tag_v <= '0;
            tag_d <= '0;
            tag_w <= '0;
        end else begin
            tag_v[0] <= mem_en;
            tag_d[0] <= d_gnt;
            tag_w[0] <= d_gnt & bus.D_WE;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_d[i] <= tag_d[i-1];
                tag_w[i] <= tag_w[i-1];
            end
        end
    end

    assign if_valid   = tag_v[LAT-1] & ~tag_d[LAT-1];
    assign d_valid    = tag_v[LAT-1] &  tag_d[LAT-1];
    assign d_is_write = tag_w[LAT-1];

    assign bus.IF_GNT    = if_gnt;
    assign bus.D_GNT     = d_gnt;
    assign bus.MEM_EN    = mem_en;
    assign bus.MEM_WE    = d_gnt & bus.D_WE;
    assign bus.MEM_ADDR  = mem_addr;
    assign bus.MEM_WDATA = mem_wdata;
    assign bus.MEM_SIZE  = mem_size;
    assign bus.MEM_SIGN  = mem_sign;
    assign bus.IF_VALID  = if_valid;
    assign bus.D_VALID   = d_valid;
    assign bus.IF_RDATA  = if_valid ? bus.MEM_RDATA : '0;
    assign bus.D_RDATA   = (d_valid && !d_is_write) ? bus.MEM_RDATA : '0;
    assign bus.STALL     = (bus.IF_REQ & ~if_gnt) | (bus.D_REQ & ~d_gnt);
endmodule

// File: tb/tb_otter_mem_arbiter.sv
// tb/tb_otter_mem_arbiter.sv - scoreboard bench for otter_mem_arbiter at LAT=1 and LAT=3
module tb_otter_mem_arbiter;
    typedef struct {
        bit          is_data;
        logic [31:0] data;
        int          due;
    } resp_t;

    logic  CLK = 1'b0;
    logic  RST = 1'b1;
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    resp_t q1[$];
    resp_t q3[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    otter_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1();
    otter_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3();

    otter_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1), .STARVE_MAX(3)) u1 (
        .CLK(CLK), .RST(RST), .bus(b1)
    );
    otter_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(3), .STARVE_MAX(3)) u3 (
        .CLK(CLK), .RST(RST), .bus(b3)
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0000_0013 : {a[15:0] ^ 16'h5A5A, a[31:16] | 16'h0001};
    endfunction

    // Memory models return data for every access (writes too) and junk when idle.
    logic [31:0] m1;
    logic [31:0] m3p [3];
    always @(posedge CLK) m1 <= b1.MEM_EN ? mem_f(b1.MEM_ADDR) : 32'hCAFE_0001;
    always @(posedge CLK) begin
        m3p[0] <= b3.MEM_EN ? mem_f(b3.MEM_ADDR) : 32'hCAFE_0003;
        m3p[1] <= m3p[0];
        m3p[2] <= m3p[1];
    end
    assign b1.MEM_RDATA = m1;
    assign b3.MEM_RDATA = m3p[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        b1.IF_REQ = 0; b1.IF_ADDR = 0; b1.D_REQ = 0; b1.D_WE = 0; b1.D_ADDR = 0;
        b1.D_WDATA = 0; b1.D_SIZE = 0; b1.D_SIGN = 0;
        b3.IF_REQ = 0; b3.IF_ADDR = 0; b3.D_REQ = 0; b3.D_WE = 0; b3.D_ADDR = 0;
        b3.D_WDATA = 0; b3.D_SIZE = 0; b3.D_SIGN = 0;
    endtask

    task automatic drive(input bit sel, input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dw, input logic [31:0] da,
                         input logic [31:0] dwd, input logic [1:0] ds, input logic dsg,
                         input logic eig, input logic edg, input logic est);
        logic        ag, adg, ast, aen, awe, asg;
        logic [31:0] aaddr, awd;
        logic [1:0]  asz;
        logic        een;
        string       p;
        resp_t       e;
        @(posedge CLK);
        #1;
        if (!sel) begin
            b1.IF_REQ = ir; b1.IF_ADDR = ia; b1.D_REQ = dr; b1.D_WE = dw; b1.D_ADDR = da;
            b1.D_WDATA = dwd; b1.D_SIZE = ds; b1.D_SIGN = dsg;
            b3.IF_REQ = 0; b3.D_REQ = 0;
        end else begin
            b3.IF_REQ = ir; b3.IF_ADDR = ia; b3.D_REQ = dr; b3.D_WE = dw; b3.D_ADDR = da;
            b3.D_WDATA = dwd; b3.D_SIZE = ds; b3.D_SIGN = dsg;
            b1.IF_REQ = 0; b1.D_REQ = 0;
        end
        #3;
        if (!sel) begin
            ag = b1.IF_GNT; adg = b1.D_GNT; ast = b1.STALL; aen = b1.MEM_EN; awe = b1.MEM_WE;
            aaddr = b1.MEM_ADDR; awd = b1.MEM_WDATA; asz = b1.MEM_SIZE; asg = b1.MEM_SIGN;
            p = "u1";
        end else begin
            ag = b3.IF_GNT; adg = b3.D_GNT; ast = b3.STALL; aen = b3.MEM_EN; awe = b3.MEM_WE;
            aaddr = b3.MEM_ADDR; awd = b3.MEM_WDATA; asz = b3.MEM_SIZE; asg = b3.MEM_SIGN;
            p = "u3";
        end
        een = eig | edg;
        chk({p, "_if_gnt"}, ag, eig);
        chk({p, "_d_gnt"}, adg, edg);
        chk({p, "_stall"}, ast, est);
        chk({p, "_mem_en"}, aen, een);
        chk({p, "_mem_we"}, awe, edg & dw);
        chk({p, "_mem_addr"}, aaddr, eig ? ia : (edg ? da : 32'h0));
        chk({p, "_mem_wdata"}, awd, een ? dwd : 32'h0);
        chk({p, "_mem_size"}, asz, eig ? 2'b10 : (edg ? ds : 2'b00));
        chk({p, "_mem_sign"}, asg, edg ? dsg : 1'b0);
        if (eig) begin
            e.is_data = 0; e.data = mem_f(ia); e.due = cyc + (sel ? 3 : 1);
            if (sel) q3.push_back(e); else q1.push_back(e);
        end
        if (edg) begin
            e.is_data = 1; e.data = dw ? 32'h0 : mem_f(da); e.due = cyc + (sel ? 3 : 1);
            if (sel) q3.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic mon(input bit sel);
        logic        iv, dv;
        logic [31:0] ird, drd;
        resp_t       e;
        string       p;
        int          qs;
        p   = sel ? "u3" : "u1";
        iv  = sel ? b3.IF_VALID : b1.IF_VALID;
        dv  = sel ? b3.D_VALID  : b1.D_VALID;
        ird = sel ? b3.IF_RDATA : b1.IF_RDATA;
        drd = sel ? b3.D_RDATA  : b1.D_RDATA;
        qs  = sel ? q3.size() : q1.size();
        if (iv || dv) begin
            if (qs == 0) begin
                total++;
                bad++;
                $display("FAIL %s_unexpected_valid actual=if%0b/d%0b required=none (t=%0t)", p, iv, dv, $time);
            end else begin
                e = sel ? q3.pop_front() : q1.pop_front();
                chk({p, "_resp_kind"}, {iv, dv}, e.is_data ? 2'b01 : 2'b10);
                chk({p, "_resp_data"}, e.is_data ? drd : ird, e.data);
                chk({p, "_other_rdata"}, e.is_data ? ird : drd, 32'h0);
                chk({p, "_resp_cycle"}, cyc, e.due);
            end
        end else begin
            chk({p, "_idle_rdata"}, ird | drd, 32'h0);
        end
    endtask

    always @(negedge CLK) mon(1'b0);
    always @(negedge CLK) mon(1'b1);

    initial begin
        logic [31:0] ia;
        logic [31:0] da;
        clear_inputs();
        @(posedge CLK);
        #2;
        chk("rst_u1_if_valid", b1.IF_VALID, 0);
        chk("rst_u1_d_valid", b1.D_VALID, 0);
        chk("rst_u3_valids", {b3.IF_VALID, b3.D_VALID}, 0);
        chk("rst_u1_stall", b1.STALL, 0);
        chk("rst_u1_mem_en", b1.MEM_EN, 0);
        @(posedge CLK);
        #3 RST = 1'b0;

        // LAT=1 single fetch, then an idle cycle with junk fields and REQ low
        drive(0, 1, 32'h100, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0);
        drive(0, 0, 32'hFFFF_0000, 0, 1, 32'h1234, 32'h5555, 2'b01, 1, 0, 0, 0);

        // Fetch alone for 10 cycles
        for (int i = 0; i < 10; i++)
            drive(0, 1, 32'h104 + 32'(4 * i), 0, 0, 0, 0, 2'b00, 0, 1, 0, 0);

        // Both requesting: D,D,D,I repeating
        ia = 32'h200;
        da = 32'h1000;
        for (int c = 0; c < 8; c++) begin
            drive(0, 1, ia, 1, 0, da, 32'h0, 2'b10, 0, (c % 4) == 3, (c % 4) != 3, 1);
            if ((c % 4) == 3) ia = ia + 4; else da = da + 4;
        end

        // Store, then a signed byte load
        drive(0, 0, 0, 1, 1, 32'h1100_0040, 32'hDEAD_BEEF, 2'b10, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0, 32'h2000_0010, 32'h0, 2'b00, 1, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);

        // LAT=3: I,D,I on consecutive cycles
        drive(1, 1, 32'h300, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0);
        drive(1, 0, 0, 1, 0, 32'h400, 0, 2'b10, 0, 0, 1, 0);
        drive(1, 1, 32'h304, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++)
            drive(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);

        // Two data reads in flight (starve_cnt raised to 2), then async reset mid-cycle
        drive(1, 1, 32'h500, 1, 0, 32'h600, 0, 2'b10, 0, 0, 1, 1);
        drive(1, 1, 32'h500, 1, 0, 32'h604, 0, 2'b10, 0, 0, 1, 1);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        clear_inputs();
        q3.delete();
        @(posedge CLK);
        #3 RST = 1'b0;

        // starve_cnt back to 0 means three D wins before fetch is forced through
        da = 32'h800;
        for (int c = 0; c < 4; c++) begin
            drive(1, 1, 32'h700, 1, 0, da, 0, 2'b10, 0, c == 3, c != 3, 1);
            da = da + 4;
        end
        drive(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);

        repeat (6) @(posedge CLK);
        #3;
        chk("u1_queue_drain", q1.size(), 0);
        chk("u3_queue_drain", q3.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/otter_mem_arbiter.md
Name: otter_mem_arbiter

Overview:
- Shares one single-ported memory port between two requesters: the OTTER instruction-fetch stage and the load/store (MEM) stage.
- Grants one requester per cycle, with data priority and a starvation guard for fetch.
- Tracks in-flight accesses and routes fixed-latency read data back to the requester that issued them.
- Emits STALL so the pipeline holds its registers while a request is not granted.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port.
- DATA_W, 32, data width.
- LAT, 1, memory read latency in cycles from MEM_EN to MEM_RDATA valid; legal range 1..4.
- STARVE_MAX, 3, consecutive cycles fetch may lose arbitration before it is forced to win; legal range 1..15.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- IF_REQ  in  1  fetch request.
- IF_ADDR  in  ADDR_W  fetch address.
- IF_GNT  out  1  fetch granted this cycle.
- IF_VALID  out  1  fetch read data valid.
- IF_RDATA  out  DATA_W  fetch read data.
- D_REQ  in  1  data request.
- D_WE  in  1  data write enable.
- D_ADDR  in  ADDR_W  data address.
- D_WDATA  in  DATA_W  store data.
- D_SIZE  in  2  access size (byte, half, word).
- D_SIGN  in  1  load sign control.
- D_GNT  out  1  data granted this cycle.
- D_VALID  out  1  data read/write completion.
- D_RDATA  out  DATA_W  load data.
- MEM_EN  out  1  memory access strobe.
- MEM_WE  out  1  memory write enable.
- MEM_ADDR  out  ADDR_W  memory address.
- MEM_WDATA  out  DATA_W  memory write data.
- MEM_SIZE  out  2  memory access size.
- MEM_SIGN  out  1  memory sign control.
- MEM_RDATA  in  DATA_W  memory read data, valid LAT cycles after MEM_EN.
- STALL  out  1  pipeline hold request.

Behaviour:
- Arbitration is combinational within a cycle.
  - Only one requester asserting: that requester is granted.
  - Both asserting: D wins, unless starve_cnt == STARVE_MAX, in which case IF wins.
  - IF_GNT and D_GNT are never both 1.
- starve_cnt is 4 bits, registered.
  - Increments when IF_REQ & D_GNT.
  - Clears when IF_GNT or !IF_REQ.
  - Saturates at STARVE_MAX.
- Memory port drive:
  - MEM_EN = IF_GNT | D_GNT.
  - MEM_ADDR, MEM_SIZE and MEM_SIGN come from the granted requester.
  - For a fetch grant: MEM_SIZE = 2'b10 (word), MEM_SIGN = 0.
  - MEM_WE = D_GNT & D_WE. MEM_WDATA = D_WDATA.
  - When MEM_EN = 0, MEM_WE = 0 and all other MEM_* outputs are 0.
- Tag pipeline: LAT-deep shift register of {valid, is_data, is_write}, loaded from the grant each cycle.
  - Stage LAT-1 output drives IF_VALID = valid & !is_data, and D_VALID = valid & is_data.
  - Response arrives exactly LAT cycles after the grant.
  - Writes also produce D_VALID (completion ack); D_RDATA = 0 for writes.
- Read data routing:
  - IF_RDATA = MEM_RDATA when IF_VALID, else 0.
  - D_RDATA = MEM_RDATA when D_VALID and not a write, else 0.
- STALL = (IF_REQ & !IF_GNT) | (D_REQ & !D_GNT).
- Back-to-back grants every cycle are supported; the tag pipeline never stalls.
- Requesters must hold REQ and all request fields stable until GNT; the arbiter does not latch request fields.
- Reset (asynchronous):
  - starve_cnt = 0; tag pipeline cleared.
  - All outputs 0, except grant/STALL/MEM_* outputs, which follow their combinational equations.
  - Reset asserted while accesses are in flight: those responses are discarded; no VALID is emitted for any grant issued before reset.
- Requests with REQ = 0 are ignored regardless of address/data values.

Test Plan:
- Reset, LAT=1, IF_REQ=1 with IF_ADDR=0x100, memory returns 0x00000013 -> IF_GNT=1 that cycle; next cycle IF_VALID=1, IF_RDATA=0x00000013; STALL=0 throughout.
- Both requesting every cycle, STARVE_MAX=3, D_REQ held high -> D_GNT for 3 cycles, then IF_GNT on 4th; pattern D,D,D,I repeats; STALL=1 on every cycle.
- D_WE=1, D_ADDR=0x11000040, D_WDATA=0xDEADBEEF, D_SIZE=2 -> MEM_WE=1 with the same addr/data; D_VALID=1 LAT cycles later with D_RDATA=0; IF_VALID stays 0.
- LAT=3, alternating single grants I,D,I on cycles 0,1,2 -> IF_VALID at cycle 3, D_VALID at cycle 4, IF_VALID at cycle 5, each carrying the memory data for its own address.
- RST pulsed asynchronously mid-cycle with 2 reads in flight (LAT=3) -> no IF_VALID/D_VALID after reset; starve_cnt=0; first post-reset request is granted normally.
- IF_REQ=1 alone for 10 cycles with D_REQ=0 -> IF_GNT every cycle, starve_cnt stays 0, STALL=0.
